// File: rtl/dir_strobe_ctrl_pkg.sv
// Shared types and helpers for the direction-register write controller.
package dir_pkg;

  typedef enum logic {
    ARMED = 1'b0,
    HELD  = 1'b1
  } dir_state_e;

  localparam int MAX_REGS = 16;

  function automatic logic [MAX_REGS-1:0] onehot(input int unsigned idx);
    return MAX_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/dir_strobe_edge.sv
// Strobe edge qualifier: one accept per rising edge of the qualified strobe.
module dir_strobe_edge
  import dir_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic q_i,
  output logic accept_o
);

  dir_state_e state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARMED;
    end else begin
      unique case (state_q)
        ARMED: if (q_i)  state_q <= HELD;
        HELD:  if (!q_i) state_q <= ARMED;
        default:         state_q <= ARMED;
      endcase
    end
  end

  // Accept is taken at the edge itself so the write lands one cycle later.
  assign accept_o = q_i & (state_q == ARMED);

endmodule

// File: rtl/dir_strobe_ctrl.sv
// N-register direction write controller with ack/err and read-back.
// Define DIR_LOCK_EN to add lock_req and per-register write locks.
module dir_strobe_ctrl
  import dir_pkg::*;
#(
  parameter  int N_REGS = 4,
  parameter  int DATA_W = 8,
  localparam int ADDR_W = $clog2(N_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [ADDR_W-1:0]        addr_in,
  input  logic                     strob_in,
  input  logic                     choose_dir_reg,
`ifdef DIR_LOCK_EN
  input  logic                     lock_req,
`endif
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [N_REGS-1:0]        strob_out_to_reg,
  output logic [N_REGS*DATA_W-1:0] dir_out,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     wr_ack,
  output logic                     wr_err
);

  logic q, accept;
  logic in_range, rd_in_range, locked;
  logic wr_ok, wr_rej;
  logic [MAX_REGS-1:0] dec;
  logic [N_REGS-1:0] strob_d, strob_q;
  logic [DATA_W-1:0] rd_d, rd_q;
  logic ack_q, err_q;
  logic [DATA_W-1:0] regs_q [N_REGS];

  assign q = strob_in & choose_dir_reg;

  dir_strobe_edge u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .q_i      (q),
    .accept_o (accept)
  );

  assign in_range    = int'(addr_in) < N_REGS;
  assign rd_in_range = int'(rd_addr) < N_REGS;
  assign dec         = onehot(32'(addr_in));

`ifdef DIR_LOCK_EN
  logic [N_REGS-1:0] lock_q;
  assign locked = in_range & lock_q[addr_in];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= '0;
    end else if (wr_ok && lock_req) begin
      lock_q[addr_in] <= 1'b1;
    end
  end
`else
  assign locked = 1'b0;
`endif

  assign wr_ok   = accept & in_range & ~locked;
  assign wr_rej  = accept & ~wr_ok;
  assign strob_d = wr_ok ? dec[N_REGS-1:0] : '0;
  assign rd_d    = rd_in_range ? regs_q[rd_addr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strob_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
    end else begin
      strob_q <= strob_d;
      ack_q   <= wr_ok;
      err_q   <= wr_rej;
      rd_q    <= rd_d;
      if (wr_ok) regs_q[addr_in] <= data_in;
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_dir
    assign dir_out[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign strob_out_to_reg = strob_q;
  assign rd_data          = rd_q;
  assign wr_ack           = ack_q;
  assign wr_err           = err_q;

endmodule

// File: doc/dir_strobe_ctrl.md
# dir_strobe_ctrl

Parametrised direction-register write controller: decodes a registered address plus strobe into a one-hot, single-cycle write pulse and holds the addressed direction registers locally. It generalises the combinational direction-register strobe decoder to N registers of configurable width, with strobe edge qualification, write acknowledge, out-of-range detection, read-back and optional per-register write lock. It sits between the host bus interface and the I/O direction logic.

## Interface
- N_REGS, 4: number of direction registers, 2..16.
- DATA_W, 8: width of each direction register.
- ADDR_W, $clog2(N_REGS) (derived, not overridable): address width.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  DATA_W  write data.
- addr_in  in  ADDR_W  target register index.
- strob_in  in  1  write strobe, synchronous to clk, may be held for many cycles.
- choose_dir_reg  in  1  block select; a write requires strob_in & choose_dir_reg.
- lock_req  in  1  (DIR_LOCK_EN only) lock the target register with this write.
- rd_addr  in  ADDR_W  read-back index.
- strob_out_to_reg  out  N_REGS  one-hot write pulse, registered.
- dir_out  out  N_REGS*DATA_W  register contents; register i at bits [i*DATA_W +: DATA_W].
- rd_data  out  DATA_W  registered read-back of register rd_addr.
- wr_ack  out  1  one-cycle pulse: write performed.
- wr_err  out  1  one-cycle pulse: write rejected.

## Operation
- Qualifier q = strob_in & choose_dir_reg.
- FSM, two states: ARMED (reset state), HELD.
- ARMED, q=1: accept request (sample addr_in, data_in, lock_req); go HELD.
- HELD: no accepts; return to ARMED on the first cycle with q=0 (strob_in low or choose_dir_reg low).
- Held strobe produces exactly one write; a new write needs q to fall and rise again.
- Accepted, addr_in < N_REGS, target unlocked: register written, strob_out_to_reg bit addr_in pulses, wr_ack pulses.
- Accepted, addr_in >= N_REGS (non-power-of-2 N_REGS) or target locked: no register change, strob_out_to_reg stays 0, wr_err pulses.
- wr_ack and wr_err are never high together; strob_out_to_reg is zero or one-hot, never multi-hot.
- rd_data = register[rd_addr], registered; an out-of-range rd_addr returns 0.

## Timing
- Reset: FSM ARMED, all registers 0, dir_out 0, strob_out_to_reg 0, rd_data 0, wr_ack 0, wr_err 0, all locks clear.
- Accept at edge k (q high before edge k, FSM ARMED); register, strob_out_to_reg, wr_ack/wr_err all valid after edge k, for exactly one cycle (pulses) or persistently (dir_out).
- Write latency 1 cycle, throughput one write per two cycles minimum (q high, low, high).
- rd_data latency 1 cycle; a read of a register written at edge k returns the new value after edge k+1.
- Reset asserted mid-operation: immediate clear of all state and outputs; a strobe held across reset release is accepted at the first edge after release (FSM starts ARMED).

## Configuration
- DIR_LOCK_EN defined: lock_req port and N_REGS lock bits exist; an accepted, in-range, unlocked write with lock_req=1 writes data and sets the target's lock bit in the same cycle; writes to a locked register give wr_err; locks clear only on reset.
- DIR_LOCK_EN undefined: no lock_req port, no lock bits; the only rejection is out-of-range address.

## Structure
- Package dir_pkg: FSM state enum (ARMED, HELD), MAX_REGS = 16 constant, helper function for one-hot decode of an index to N_REGS bits.
- One sub-module, dir_strobe_edge: the ARMED/HELD FSM, input q, output single-cycle accept pulse.
- Top holds the capture registers, register array, lock bits, read-back mux.

## Test plan
- N_REGS=4, DATA_W=8: write 0xA5 to addr 2 with one-cycle strobe -> strob_out_to_reg=4'b0100 for one cycle, wr_ack one cycle, dir_out[23:16]=0xA5.
- Strobe held 10 cycles at addr 1, data 0x3C -> exactly one pulse 4'b0010, one wr_ack; FSM returns ARMED the cycle after strobe drops.
- N_REGS=3: write to addr 3 -> wr_err one cycle, strob_out_to_reg=0, dir_out unchanged.
- strob_in held high, choose_dir_reg toggles 1-0-1 -> two writes, two wr_ack pulses.
- DIR_LOCK_EN: write 0x11 with lock_req=1 to addr 0, then 0x22 to addr 0 -> first wr_ack, second wr_err, register stays 0x11; rst_n low -> lock cleared, register 0.
- Reset asserted during HELD with strobe held, released with strobe still high -> one new write after release; rd_addr=2 after write returns value one cycle later.
